// File: rtl/abc_capture_fifo.sv
// First-word-fall-through capture FIFO for a/b/c triplets with a per-entry sum,
// fill level, full/empty and a sticky overflow flag.
module abc_capture_fifo #(
    parameter  int unsigned W     = 8,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic [W-1:0]  in_c,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_a,
    output logic [W-1:0]  out_b,
    output logic [W-1:0]  out_c,
    output logic [W+1:0]  out_sum,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    input  logic          clr_ovf
);

    logic [3*W-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           ovf_q, ovf_d;
    logic           push, pop;
    logic [3*W-1:0] rd_data;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push  = in_valid && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (in_valid && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is intentionally not reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b, in_c};
        end
    end

    always_comb begin
        rd_data   = mem_q[rd_ptr_q];
        out_valid = !empty;
        out_a     = '0;
        out_b     = '0;
        out_c     = '0;
        if (!empty) begin
            out_a = rd_data[3*W-1:2*W];
            out_b = rd_data[2*W-1:W];
            out_c = rd_data[W-1:0];
        end
        out_sum = {2'b00, out_a} + {2'b00, out_b} + {2'b00, out_c};
    end

    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_abc_capture_fifo.sv
// Self-checking bench for abc_capture_fifo: directed scenarios plus a random
// phase, all checked against a queue-based reference model.
module tb_abc_capture_fifo;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_a = '0, in_b = '0, in_c = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_a, out_b, out_c;
    logic [W+1:0]  out_sum;
    logic [3:0]    count;
    logic          full, empty, overflow;
    logic          clr_ovf = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;
    string phase = "init";

    logic [23:0] q[$];
    logic        m_ovf = 1'b0;

    abc_capture_fifo #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_sum   (out_sum),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s:%s observed=%0h expected=%0h", phase, tag, obs, exp);
    endtask

    task automatic check_all();
        int n;
        logic [23:0] h;
        n = q.size();
        h = (n > 0) ? q[0] : 24'h0;
        chk("out_valid", {31'b0, out_valid}, (n > 0) ? 1 : 0);
        chk("out_a", {24'b0, out_a}, {24'b0, h[23:16]});
        chk("out_b", {24'b0, out_b}, {24'b0, h[15:8]});
        chk("out_c", {24'b0, out_c}, {24'b0, h[7:0]});
        chk("out_sum", {22'b0, out_sum}, 32'(h[23:16]) + 32'(h[15:8]) + 32'(h[7:0]));
        chk("count", {28'b0, count}, 32'(n));
        chk("full", {31'b0, full}, (n == DEPTH) ? 1 : 0);
        chk("empty", {31'b0, empty}, (n == 0) ? 1 : 0);
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    endtask

    // One clock: drive inputs, predict from the model, advance, then compare.
    task automatic cycle(input logic iv, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic rdy, input logic clr);
        logic m_pop, m_push, m_set;
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        in_c      = c;
        out_ready = rdy;
        clr_ovf   = clr;
        m_pop  = (q.size() > 0) && rdy;
        m_push = iv && ((q.size() < DEPTH) || m_pop);
        m_set  = iv && (q.size() == DEPTH) && !m_pop;
        @(posedge clk);
        #1;
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back({a, b, c});
        if (m_set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        check_all();
    endtask

    initial begin
        // Reset then idle
        phase = "reset";
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #2 rst = 1'b1;
        cycle(0, 0, 0, 0, 0, 0);

        // Single push, then pop
        phase = "single";
        cycle(1, 8'h00, 8'h01, 8'h02, 0, 0);
        chk("single_sum", {22'b0, out_sum}, 3);
        cycle(0, 0, 0, 0, 1, 0);
        chk("single_empty", {31'b0, empty}, 1);

        // Fill and overflow
        phase = "fill";
        for (int k = 0; k < 8; k++) cycle(1, 8'(k), 8'(k + 1), 8'(k + 2), 0, 0);
        chk("fill_full", {31'b0, full}, 1);
        phase = "ovf";
        cycle(1, 8'hFF, 8'hFF, 8'hFF, 0, 0);
        chk("ovf_set", {31'b0, overflow}, 1);

        // Clear priority at full
        phase = "clr";
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 8'hAA, 8'hBB, 8'hCC, 0, 1);
        chk("set_wins", {31'b0, overflow}, 1);
        cycle(0, 0, 0, 0, 0, 1);
        chk("clr_alone", {31'b0, overflow}, 0);

        // Drain in order
        phase = "drain";
        for (int i = 0; i < 8; i++) begin
            if (i == 0) chk("first_sum", {22'b0, out_sum}, 3);
            if (i == 7) chk("last_sum", {22'b0, out_sum}, 24);
            cycle(0, 0, 0, 0, 1, 0);
        end

        // Full with simultaneous push + pop
        phase = "fullpp";
        for (int k = 0; k < 8; k++) cycle(1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0);
        cycle(1, 8'h10, 8'h20, 8'h30, 1, 0);
        chk("pp_count", {28'b0, count}, 8);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                chk("pp_emerge_a", {24'b0, out_a}, 32'h10);
                chk("pp_emerge_sum", {22'b0, out_sum}, 32'h60);
            end
            cycle(0, 0, 0, 0, 1, 0);
        end

        // Streaming with wrap and max sum
        phase = "wrap";
        for (int i = 0; i < 20; i++) begin
            cycle(1, 8'hFF, 8'hFF, 8'hFF, 1, 0);
            chk("wrap_sum", {22'b0, out_sum}, 765);
        end

        // Random traffic with shifting occupancy bias
        phase = "random";
        for (int i = 0; i < 400; i++) begin
            logic iv, rdy, clr;
            int bias;
            bias = (i / 50) % 3;
            iv  = ($urandom_range(0, 3) >= 1 + bias);
            rdy = ($urandom_range(0, 3) >= 2 - bias);
            clr = ($urandom_range(0, 15) == 0);
            cycle(iv, 8'($urandom), 8'($urandom), 8'($urandom), rdy, clr);
        end

        // Mid-operation asynchronous reset at count 5
        phase = "midrst";
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) cycle(1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0);
        chk("pre_rst_count", {28'b0, count}, 5);
        #2 rst = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        check_all();
        #2 rst = 1'b1;
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 8'h12, 8'h34, 8'h56, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
